// File: rtl/hps_lw_mailbox_if.sv
// Avalon-MM slave bus plus the two fabric-side valid/ready streams of the HPS mailbox.
interface hps_lw_mailbox_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              irq;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, tx_ready, rx_data, rx_valid,
        output avs_readdata, tx_data, tx_valid, rx_ready, irq
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, tx_ready, rx_data, rx_valid,
        input  avs_readdata, tx_data, tx_valid, rx_ready, irq
    );
endinterface

// File: rtl/hps_lw_mailbox.sv
// HPS lightweight-bridge mailbox: Avalon-MM register file fronting a TX and an RX word FIFO,
// with sticky overflow/underflow flags and a threshold-based level interrupt.
module hps_lw_mailbox #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    hps_lw_mailbox_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_THRESH = 2'd3
    } reg_addr_e;

    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];

    logic [PTR_W-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PTR_W-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d;
    logic [DATA_W-1:0] tx_head_q, tx_head_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              irq_en_q, irq_en_d, irq_q, irq_d;

    logic              wr_data, wr_ctrl, wr_thresh, rd_data;
    logic              flush, clr_sticky;
    logic              tx_full, tx_pop, tx_push, rx_push, rx_pop;
    logic [31:0]       status_w;

    // A push into a full TX FIFO is still accepted when the fabric pops the same cycle.
    always_comb begin
        wr_data    = bus.avs_write && (bus.avs_address == ADDR_DATA);
        wr_ctrl    = bus.avs_write && (bus.avs_address == ADDR_CTRL);
        wr_thresh  = bus.avs_write && (bus.avs_address == ADDR_THRESH);
        rd_data    = bus.avs_read  && (bus.avs_address == ADDR_DATA);
        flush      = wr_ctrl && bus.avs_writedata[2];
        clr_sticky = wr_ctrl && bus.avs_writedata[1];
        tx_full    = (tx_cnt_q == DEPTH_C);
        tx_pop     = (tx_cnt_q != '0) && bus.tx_ready;
        tx_push    = wr_data && (!tx_full || tx_pop);
        rx_push    = bus.rx_valid && rx_ready_q;
        rx_pop     = rd_data && (rx_cnt_q != '0);
    end

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(tx_pop);
        tx_cnt_d    = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(rx_pop);
        rx_cnt_d    = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
        if (flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_cnt_d    = '0;
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_cnt_d    = '0;
        end
        rx_ready_d = (rx_cnt_d != DEPTH_C);

        // The word being written this cycle may become the new head before it lands in memory.
        if (tx_cnt_d == '0) begin
            tx_head_d = '0;
        end else if (tx_push && (tx_wr_ptr_q == tx_rd_ptr_d)) begin
            tx_head_d = bus.avs_writedata;
        end else begin
            tx_head_d = tx_mem[tx_rd_ptr_d];
        end
    end

    always_comb begin
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (clr_sticky) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr_data && tx_full && !tx_pop) begin
            ovf_d = 1'b1;
        end
        if (rd_data && (rx_cnt_q == '0)) begin
            unf_d = 1'b1;
        end
        if (wr_ctrl) begin
            irq_en_d = bus.avs_writedata[0];
        end
        if (wr_thresh) begin
            if (bus.avs_writedata == '0) begin
                thresh_d = CNT_W'(1);
            end else if (bus.avs_writedata > DATA_W'(DEPTH)) begin
                thresh_d = DEPTH_C;
            end else begin
                thresh_d = bus.avs_writedata[CNT_W-1:0];
            end
        end
        irq_d = irq_en_d && ((rx_cnt_d >= thresh_d) || ovf_d || unf_d);
    end

    // Read data always reflects the state before any same-cycle write.
    always_comb begin
        status_w        = '0;
        status_w[0]     = (rx_cnt_q == '0);
        status_w[1]     = tx_full;
        status_w[2]     = ovf_q;
        status_w[3]     = unf_q;
        status_w[4]     = irq_q;
        status_w[15:8]  = 8'(rx_cnt_q);
        status_w[23:16] = 8'(tx_cnt_q);

        rdata_d = rdata_q;
        if (bus.avs_read) begin
            case (reg_addr_e'(bus.avs_address))
                ADDR_DATA:   rdata_d = rx_pop ? rx_mem[rx_rd_ptr_q] : '0;
                ADDR_STATUS: rdata_d = status_w[DATA_W-1:0];
                ADDR_CTRL:   rdata_d = DATA_W'(irq_en_q);
                ADDR_THRESH: rdata_d = DATA_W'(thresh_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= bus.avs_writedata;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_head_q   <= '0;
            rdata_q     <= '0;
            rx_ready_q  <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            thresh_q    <= CNT_W'(1);
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_head_q   <= tx_head_d;
            rdata_q     <= rdata_d;
            rx_ready_q  <= rx_ready_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            thresh_q    <= thresh_d;
        end
    end

    assign bus.avs_readdata = rdata_q;
    assign bus.tx_data      = tx_head_q;
    assign bus.tx_valid     = (tx_cnt_q != '0);
    assign bus.rx_ready     = rx_ready_q;
    assign bus.irq          = irq_q;
endmodule

// File: tb/tb_hps_lw_mailbox.sv
// Directed bench for hps_lw_mailbox: register map, FIFO ordering, overflow/underflow,
// threshold interrupt, flush and asynchronous reset, each scenario in its own task.
module tb_hps_lw_mailbox;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    hps_lw_mailbox_if #(.DATA_W(DATA_W)) mb ();

    hps_lw_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (mb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Every helper starts and ends 1 ns after a rising edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        mb.avs_address   = addr;
        mb.avs_writedata = data;
        mb.avs_write     = 1'b1;
        @(posedge clk); #1;
        mb.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        mb.avs_address = addr;
        mb.avs_read    = 1'b1;
        @(posedge clk); #1;
        mb.avs_read    = 1'b0;
        data = mb.avs_readdata;
    endtask

    task automatic rx_push(input logic [31:0] data);
        mb.rx_data  = data;
        mb.rx_valid = 1'b1;
        @(posedge clk); #1;
        mb.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        n_checks++; if (mb.avs_readdata !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_readdata: got 0x%08h, expected 0x00000000", mb.avs_readdata); end
        n_checks++; if ({mb.irq, mb.rx_ready, mb.tx_valid} !== 3'b010) begin n_errors++; $display("[TB] FAIL reset_flags {irq,rx_ready,tx_valid}: got %b, expected 010", {mb.irq, mb.rx_ready, mb.tx_valid}); end
        n_checks++; if (mb.tx_data !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_tx_data: got 0x%08h, expected 0x00000000", mb.tx_data); end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_errors++; $display("[TB] FAIL reset_status: got 0x%08h, expected 0x00000001", v); end
        bus_read(2'd3, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_errors++; $display("[TB] FAIL reset_thresh: got 0x%08h, expected 0x00000001", v); end
        bus_read(2'd2, v);
        n_checks++; if (v !== 32'h0000_0000) begin n_errors++; $display("[TB] FAIL reset_ctrl: got 0x%08h, expected 0x00000000", v); end
    endtask

    task automatic test_thresh();
        logic [31:0] v;
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, v);
        n_checks++; if (v !== 32'd1) begin n_errors++; $display("[TB] FAIL thresh_zero: got %0d, expected 1", v); end
        bus_write(2'd3, 32'd17);
        bus_read(2'd3, v);
        n_checks++; if (v !== 32'd16) begin n_errors++; $display("[TB] FAIL thresh_clamp: got %0d, expected 16", v); end
        bus_write(2'd3, 32'd5);
        bus_read(2'd3, v);
        n_checks++; if (v !== 32'd5) begin n_errors++; $display("[TB] FAIL thresh_normal: got %0d, expected 5", v); end
        bus_write(2'd3, 32'd1);
    endtask

    task automatic test_tx_overflow();
        logic [31:0] v;
        mb.tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'hA5A5_0001 + 32'(i));
        bus_write(2'd0, 32'hDEAD_BEEF);
        n_checks++; if ({mb.tx_valid, mb.tx_data} !== {1'b1, 32'hA5A5_0001}) begin n_errors++; $display("[TB] FAIL tx_head_stable: got valid=%b data=0x%08h, expected valid=1 data=0xa5a50001", mb.tx_valid, mb.tx_data); end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0010_0007) begin n_errors++; $display("[TB] FAIL tx_full_status: got 0x%08h, expected 0x00100007", v); end
        mb.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if ({mb.tx_valid, mb.tx_data} !== {1'b1, 32'hA5A5_0001 + 32'(i)}) begin n_errors++; $display("[TB] FAIL tx_drain[%0d]: got valid=%b data=0x%08h, expected valid=1 data=0x%08h", i, mb.tx_valid, mb.tx_data, 32'hA5A5_0001 + 32'(i)); end
            @(posedge clk); #1;
        end
        mb.tx_ready = 1'b0;
        n_checks++; if (mb.tx_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL tx_drained_empty: got tx_valid=%b, expected 0", mb.tx_valid); end
        bus_write(2'd2, 32'h2);
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_errors++; $display("[TB] FAIL ovf_cleared: got 0x%08h, expected 0x00000001", v); end
    endtask

    task automatic test_rx_irq();
        logic [31:0] v;
        bus_write(2'd3, 32'd3);
        bus_write(2'd2, 32'h1);
        rx_push(32'h11);
        rx_push(32'h22);
        n_checks++; if (mb.irq !== 1'b0) begin n_errors++; $display("[TB] FAIL irq_below_thresh: got %b, expected 0", mb.irq); end
        rx_push(32'h33);
        n_checks++; if (mb.irq !== 1'b1) begin n_errors++; $display("[TB] FAIL irq_at_thresh: got %b, expected 1", mb.irq); end
        bus_read(2'd0, v);
        n_checks++; if (v !== 32'h11) begin n_errors++; $display("[TB] FAIL rx_read0: got 0x%08h, expected 0x00000011", v); end
        n_checks++; if (mb.irq !== 1'b0) begin n_errors++; $display("[TB] FAIL irq_after_pop: got %b, expected 0", mb.irq); end
        bus_read(2'd0, v);
        n_checks++; if (v !== 32'h22) begin n_errors++; $display("[TB] FAIL rx_read1: got 0x%08h, expected 0x00000022", v); end
        bus_read(2'd0, v);
        n_checks++; if (v !== 32'h33) begin n_errors++; $display("[TB] FAIL rx_read2: got 0x%08h, expected 0x00000033", v); end
        bus_read(2'd0, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("[TB] FAIL rx_underflow_data: got 0x%08h, expected 0x00000000", v); end
        n_checks++; if (mb.irq !== 1'b1) begin n_errors++; $display("[TB] FAIL irq_on_unf: got %b, expected 1", mb.irq); end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_0019) begin n_errors++; $display("[TB] FAIL unf_status: got 0x%08h, expected 0x00000019", v); end
        bus_write(2'd2, 32'h3);
        n_checks++; if (mb.irq !== 1'b0) begin n_errors++; $display("[TB] FAIL irq_after_clear: got %b, expected 0", mb.irq); end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_errors++; $display("[TB] FAIL status_after_clear: got 0x%08h, expected 0x00000001", v); end
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'd1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) rx_push(32'h100 + 32'(i));
        n_checks++; if (mb.rx_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL rx_full_ready: got %b, expected 0", mb.rx_ready); end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_1000) begin n_errors++; $display("[TB] FAIL rx_full_status: got 0x%08h, expected 0x00001000", v); end
        mb.rx_data  = 32'h1FF;
        mb.rx_valid = 1'b1;
        bus_read(2'd0, v);
        n_checks++; if (v !== 32'h100) begin n_errors++; $display("[TB] FAIL rx_full_pop: got 0x%08h, expected 0x00000100", v); end
        n_checks++; if (mb.rx_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL rx_ready_after_pop: got %b, expected 1", mb.rx_ready); end
        @(posedge clk); #1;
        mb.rx_valid = 1'b0;
        n_checks++; if (mb.rx_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL rx_refilled_ready: got %b, expected 0", mb.rx_ready); end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_1000) begin n_errors++; $display("[TB] FAIL rx_refilled_status: got 0x%08h, expected 0x00001000", v); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 32'h101 + 32'(i) : 32'h1FF;
            bus_read(2'd0, v);
            n_checks++; if (v !== exp) begin n_errors++; $display("[TB] FAIL rx_order[%0d]: got 0x%08h, expected 0x%08h", i, v, exp); end
        end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_errors++; $display("[TB] FAIL rx_drained_status: got 0x%08h, expected 0x00000001", v); end
    endtask

    task automatic test_flush();
        logic [31:0] v;
        mb.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h500 + 32'(i));
        for (int i = 0; i < 7; i++) rx_push(32'h700 + 32'(i));
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0005_0700) begin n_errors++; $display("[TB] FAIL pre_flush_status: got 0x%08h, expected 0x00050700", v); end
        mb.rx_data  = 32'hBAD;
        mb.rx_valid = 1'b1;
        bus_write(2'd2, 32'h4);
        mb.rx_valid = 1'b0;
        n_checks++; if (mb.tx_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL flush_tx_valid: got %b, expected 0", mb.tx_valid); end
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_errors++; $display("[TB] FAIL flush_status: got 0x%08h, expected 0x00000001", v); end
        bus_read(2'd2, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("[TB] FAIL flush_ctrl_read: got 0x%08h, expected 0x00000000", v); end
        bus_read(2'd0, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("[TB] FAIL flush_word_lost: got 0x%08h, expected 0x00000000", v); end
        bus_write(2'd2, 32'h2);
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        mb.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h800 + 32'(i));
        for (int i = 0; i < 8; i++) rx_push(32'h900 + 32'(i));
        bus_write(2'd2, 32'h1);
        bus_read(2'd0, v);
        n_checks++; if (v !== 32'h900) begin n_errors++; $display("[TB] FAIL pre_reset_read: got 0x%08h, expected 0x00000900", v); end
        n_checks++; if ({mb.irq, mb.tx_valid} !== 2'b11) begin n_errors++; $display("[TB] FAIL pre_reset_flags {irq,tx_valid}: got %b, expected 11", {mb.irq, mb.tx_valid}); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mb.avs_readdata !== 32'h0) begin n_errors++; $display("[TB] FAIL async_readdata: got 0x%08h, expected 0x00000000", mb.avs_readdata); end
        n_checks++; if ({mb.irq, mb.rx_ready, mb.tx_valid} !== 3'b010) begin n_errors++; $display("[TB] FAIL async_flags {irq,rx_ready,tx_valid}: got %b, expected 010", {mb.irq, mb.rx_ready, mb.tx_valid}); end
        n_checks++; if (mb.tx_data !== 32'h0) begin n_errors++; $display("[TB] FAIL async_tx_data: got 0x%08h, expected 0x00000000", mb.tx_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_read(2'd1, v);
        n_checks++; if (v !== 32'h0000_0001) begin n_errors++; $display("[TB] FAIL post_reset_status: got 0x%08h, expected 0x00000001", v); end
        bus_read(2'd2, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("[TB] FAIL post_reset_ctrl: got 0x%08h, expected 0x00000000", v); end
    endtask

    initial begin
        rst_n            = 1'b0;
        mb.avs_address   = 2'd0;
        mb.avs_read      = 1'b0;
        mb.avs_write     = 1'b0;
        mb.avs_writedata = '0;
        mb.tx_ready      = 1'b0;
        mb.rx_data       = '0;
        mb.rx_valid      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        test_thresh();
        test_tx_overflow();
        test_rx_irq();
        test_back_to_back();
        test_flush();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hps_lw_mailbox.md
Name: hps_lw_mailbox

Overview:
- Parametrised Avalon-MM slave on the HPS lightweight H2F bridge.
- Gives the HPS and fabric logic a buffered, bidirectional word mailbox.
- Contains two synchronous FIFOs:
  - TX FIFO: HPS writes, fabric consumes through a valid/ready stream.
  - RX FIFO: fabric produces through a valid/ready stream, HPS reads.
- Provides sticky error flags and a threshold-based, level-sensitive interrupt toward the HPS F2H IRQ input.

Parameters:
- DATA_W, 32, width of mailbox words and of the Avalon data bus (8..32).
- DEPTH, 16, entries per FIFO; power of two, 2..128.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk_clk  in  1  single system clock, rising edge.
- reset_reset_n  in  1  asynchronous active-low reset; deassertion is synchronised upstream.
- avs_address  in  2  word address of the register.
- avs_read  in  1  read strobe, one cycle per access.
- avs_write  in  1  write strobe, one cycle per access.
- avs_writedata  in  DATA_W  write data.
- avs_readdata  out  DATA_W  read data, valid exactly 1 cycle after avs_read.
- tx_data  out  DATA_W  head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  fabric accepts tx_data when tx_valid and tx_ready are both high.
- rx_data  in  DATA_W  word from the fabric.
- rx_valid  in  1  fabric offers rx_data.
- rx_ready  out  1  RX FIFO not full.
- irq  out  1  level interrupt to the HPS.

Behaviour:
- Reset (asynchronous, reset_reset_n=0):
  - Both FIFO pointers and counts go to 0; stickies clear; irq_en=0; thresh=1.
  - Outputs: avs_readdata=0, tx_valid=0, rx_ready=1, irq=0, tx_data=0.
  - Reset mid-transfer discards all contents. No partial access survives.
- Register map (word addresses):
  - 0 DATA:
    - Write pushes avs_writedata into TX. If TX is full, the word is dropped and the OVF sticky is set.
    - Read returns the RX head and pops it. If RX is empty, the read returns 0, sets the UNF sticky and pops nothing.
  - 1 STATUS (RO):
    - bit0 rx_empty, bit1 tx_full, bit2 OVF, bit3 UNF, bit4 irq.
    - bits[15:8] rx_count, zero-extended.
    - bits[23:16] tx_count.
    - Other bits 0.
  - 2 CTRL:
    - bit0 irq_en (R/W).
    - bit1 W1C: clears both stickies; reads 0.
    - bit2 flush: self-clearing; empties both FIFOs in the write cycle; reads 0.
  - 3 THRESH:
    - R/W, low CNT_W bits are stored.
    - A written value of 0 is stored as 1.
    - A value greater than DEPTH is stored as DEPTH.
- Writes to unused bits are ignored. Read and write in the same cycle: write takes effect and the read returns the pre-write value.
- Read latency is fixed at 1; there is no waitrequest. For a DATA read the pop takes effect in the read cycle, so back-to-back reads return consecutive entries.
- TX FIFO:
  - Push on a valid DATA write when not full; pop when tx_valid && tx_ready.
  - Push and pop in the same cycle leave the count unchanged. This is permitted even when full, because the pop frees the slot first.
  - tx_data is the registered head (FWFT); it is stable while tx_valid && !tx_ready.
- RX FIFO:
  - Push when rx_valid && rx_ready; rx_ready = (rx_count != DEPTH), driven from a register.
  - HPS pop and fabric push in the same cycle leave the count unchanged.
- Pointers wrap modulo DEPTH. Counts saturate naturally at 0..DEPTH and never wrap.
- Flush has priority over a same-cycle push or pop on either FIFO; all such transfers are lost.
- irq is registered: irq = irq_en && ((rx_count >= thresh) || OVF || UNF), evaluated on the post-update state. It asserts 1 cycle after the triggering event and deasserts 1 cycle after the cause is removed.
- The stickies are set only by the events above and cleared only by reset or CTRL bit1. If set and clear fall in the same cycle, set wins.

Test Plan:
- After reset: STATUS reads 0x00000001, irq=0, rx_ready=1, tx_valid=0. Read THRESH → 1.
- Write 0xA5A5_0001..0xA5A5_0010 to DATA (16 words) with tx_ready=0, then a 17th word 0xDEAD_BEEF:
  - STATUS → tx_full=1, OVF=1, tx_count=16.
  - Raise tx_ready: the fabric sees 0xA5A5_0001..0010 in order and 0xDEADBEEF never appears.
- Fabric pushes 3 words 0x11, 0x22, 0x33, with irq_en=1 and THRESH=3:
  - irq rises on the cycle after the 3rd push.
  - DATA reads return 0x11, 0x22, 0x33; irq falls 1 cycle after the first read.
  - A 4th read returns 0, sets UNF and reasserts irq.
  - CTRL write 0x3 clears the stickies; irq=0 one cycle later.
- With RX full (16 entries), hold rx_valid=1 and issue a DATA read in the same cycle as the fabric push: rx_count stays 16 and the next 16 reads return the entries in FIFO order.
- With TX holding 5 and RX holding 7 entries, write CTRL=0x4 while rx_valid=1: both counts read 0, the pushed word is lost, tx_valid=0.
- Assert reset_reset_n=0 for 1 cycle while both FIFOs are half full and tx_valid=1: all outputs return to reset values immediately, with no wait for a clock edge.
